// File: rtl/ccff_cfg_pkg.sv
// Shared types and sizing helpers for the CCFF mode-chain loader.
package ccff_cfg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } ccff_state_e;

   // Mode select width of the IO clock-output wrapper.
   localparam int MODE_WIDTH_DEF = 7;
   localparam int NUM_WORDS_DEF  = 4;

   // Bits needed for a counter that must hold 0..max_val inclusive.
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/ccff_tail_deserializer.sv
// Collects bits leaving a configuration chain tail into WIDTH-bit words,
// bit 0 first, and pulses rb_valid for one cycle per completed word.
module ccff_tail_deserializer
   import ccff_cfg_pkg::*;
#(
   parameter int WIDTH = MODE_WIDTH_DEF
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             sample_en,
   input  logic             tail,
   output logic [WIDTH-1:0] rb_word,
   output logic             rb_valid
);

   localparam int CW = cnt_w(WIDTH - 1);

   logic [WIDTH-1:0] rb_shift_q, rb_shift_d;
   logic [CW-1:0]    rbcnt_q, rbcnt_d;
   logic [WIDTH-1:0] rb_word_q, rb_word_d;
   logic             rb_valid_q, rb_valid_d;
   logic [WIDTH-1:0] fill;

   // Drop the sampled tail bit into its slot; publish the word on the last bit.
   always_comb begin
      rb_shift_d  = rb_shift_q;
      rbcnt_d     = rbcnt_q;
      rb_word_d   = rb_word_q;
      rb_valid_d  = 1'b0;
      fill        = rb_shift_q;
      fill[rbcnt_q] = tail;
      if (clr) begin
         rb_shift_d = '0;
         rbcnt_d    = '0;
      end else if (sample_en) begin
         if (rbcnt_q == CW'(WIDTH - 1)) begin
            rb_word_d  = fill;
            rb_valid_d = 1'b1;
            rbcnt_d    = '0;
            rb_shift_d = '0;
         end else begin
            rb_shift_d = fill;
            rbcnt_d    = rbcnt_q + CW'(1);
         end
      end
   end

   // Readback state; reset discards any partial word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rb_shift_q <= '0;
         rbcnt_q    <= '0;
         rb_word_q  <= '0;
         rb_valid_q <= 1'b0;
      end else begin
         rb_shift_q <= rb_shift_d;
         rbcnt_q    <= rbcnt_d;
         rb_word_q  <= rb_word_d;
         rb_valid_q <= rb_valid_d;
      end
   end

   assign rb_word  = rb_word_q;
   assign rb_valid = rb_valid_q;

endmodule

// File: rtl/ccff_mode_chain_loader.sv
// Serializes per-tile mode words onto one CCFF chain head (word 0 / bit 0
// first) and repacks the bits leaving the tail into readback words.
module ccff_mode_chain_loader
   import ccff_cfg_pkg::*;
#(
   parameter int MODE_WIDTH = MODE_WIDTH_DEF,
   parameter int NUM_WORDS  = NUM_WORDS_DEF
)(
   input  logic                  prog_clk,
   input  logic                  prog_reset_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   input  logic [MODE_WIDTH-1:0] cfg_word,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   output logic                  ccff_head,
   output logic                  ccff_shift_en,
   input  logic                  ccff_tail,
   output logic [MODE_WIDTH-1:0] rb_word,
   output logic                  rb_valid
);

   localparam int BC_W = cnt_w(MODE_WIDTH);
   localparam int WC_W = cnt_w(NUM_WORDS);

   ccff_state_e           state_q, state_d;
   logic [MODE_WIDTH-1:0] sh_q, sh_d;
   logic [BC_W-1:0]       bitcnt_q, bitcnt_d;
   logic [WC_W-1:0]       words_q, words_d;
   logic                  accept;
   logic                  last_shift;
   logic                  load_start;

   // Next state and chain-side outputs. A new word may be taken on the same
   // edge that shifts out the last bit of the previous one, so a steady
   // cfg_valid stream keeps the chain moving without bubbles.
   always_comb begin
      state_d    = state_q;
      sh_d       = sh_q;
      bitcnt_d   = bitcnt_q;
      words_d    = words_q;
      load_start = 1'b0;

      busy          = (state_q == ST_SHIFT);
      done          = (state_q == ST_DONE);
      ccff_shift_en = busy && (bitcnt_q != '0);
      ccff_head     = sh_q[0];
      cfg_ready     = busy && (words_q < WC_W'(NUM_WORDS)) &&
                      ((bitcnt_q == '0) || ((bitcnt_q == BC_W'(1)) && ccff_shift_en));
      accept        = cfg_valid && cfg_ready;
      last_shift    = ccff_shift_en && (bitcnt_q == BC_W'(1)) &&
                      (words_q == WC_W'(NUM_WORDS));

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               load_start = 1'b1;
               state_d    = ST_SHIFT;
               sh_d       = '0;
               bitcnt_d   = '0;
               words_d    = '0;
            end
         end
         ST_SHIFT: begin
            if (ccff_shift_en) begin
               sh_d     = sh_q >> 1;
               bitcnt_d = bitcnt_q - BC_W'(1);
            end
            if (accept) begin
               sh_d     = cfg_word;
               bitcnt_d = BC_W'(MODE_WIDTH);
               words_d  = words_q + WC_W'(1);
            end
            if (last_shift) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Loader state; reset aborts a load in flight.
   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         state_q  <= ST_IDLE;
         sh_q     <= '0;
         bitcnt_q <= '0;
         words_q  <= '0;
      end else begin
         state_q  <= state_d;
         sh_q     <= sh_d;
         bitcnt_q <= bitcnt_d;
         words_q  <= words_d;
      end
   end

   ccff_tail_deserializer #(.WIDTH(MODE_WIDTH)) u_tail_deser (
      .clk       (prog_clk),
      .rst_n     (prog_reset_n),
      .clr       (load_start),
      .sample_en (ccff_shift_en),
      .tail      (ccff_tail),
      .rb_word   (rb_word),
      .rb_valid  (rb_valid)
   );

endmodule

// File: tb/tb_ccff_mode_chain_loader.sv
// Bench for ccff_mode_chain_loader: a bit-level chain model sits on the
// head/tail pins; each load is checked against the words sent and the
// chain contents that existed before the load.
module tb_ccff_mode_chain_loader;

   localparam int MW  = 7;
   localparam int NW  = 4;
   localparam int LEN = MW * NW;

   logic          prog_clk     = 1'b0;
   logic          prog_reset_n = 1'b0;
   logic          start        = 1'b0;
   logic          cfg_valid    = 1'b0;
   logic [MW-1:0] cfg_word     = '0;
   logic          busy, done, cfg_ready, ccff_head, ccff_shift_en, ccff_tail, rb_valid;
   logic [MW-1:0] rb_word;

   int n_vec = 0;
   int n_err = 0;

   ccff_mode_chain_loader #(.MODE_WIDTH(MW), .NUM_WORDS(NW)) dut (
      .prog_clk      (prog_clk),
      .prog_reset_n  (prog_reset_n),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .cfg_word      (cfg_word),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .ccff_head     (ccff_head),
      .ccff_shift_en (ccff_shift_en),
      .ccff_tail     (ccff_tail),
      .rb_word       (rb_word),
      .rb_valid      (rb_valid)
   );

   always #5 prog_clk = ~prog_clk;

   // Chain model: bit 0 at the head, bit LEN-1 at the tail.
   bit [LEN-1:0] chain;
   assign ccff_tail = chain[LEN-1];
   always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[LEN-2:0], ccff_head};

   // Monitor: head stream, readback words, shift/done timing.
   logic          mon_clr = 1'b0;
   bit            head_q[$];
   logic [MW-1:0] rb_q[$];
   int nshift = 0, ndone = 0, cyc = 0, first_cyc = -1, last_cyc = -1, done_cyc = -1;
   logic done_rb = 1'b0, done_busy = 1'b0;

   always @(posedge prog_clk) begin
      cyc <= cyc + 1;
      if (mon_clr) begin
         head_q.delete();
         rb_q.delete();
         nshift    <= 0;
         ndone     <= 0;
         first_cyc <= -1;
         last_cyc  <= -1;
         done_cyc  <= -1;
      end else begin
         if (ccff_shift_en) begin
            head_q.push_back(ccff_head);
            if (nshift == 0) first_cyc <= cyc;
            last_cyc <= cyc;
            nshift   <= nshift + 1;
         end
         if (rb_valid) rb_q.push_back(rb_word);
         if (done) begin
            ndone     <= ndone + 1;
            done_cyc  <= cyc;
            done_rb   <= rb_valid;
            done_busy <= busy;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Tile k's mode word as held in the chain (tile 0 nearest the tail).
   function automatic logic [MW-1:0] chain_word(input bit [LEN-1:0] c, input int k);
      logic [MW-1:0] w;
      for (int b = 0; b < MW; b++) w[b] = c[LEN-1-(k*MW+b)];
      return w;
   endfunction

   // One full load. gap[k] (k>0) = cycles the chain must idle before word k.
   // poke pulses start while busy and again during the done cycle.
   task automatic do_load(input logic [MW-1:0] w [NW], input int gap [NW], input bit poke);
      logic [MW-1:0] old [NW];
      logic [MW-1:0] hw;
      int  exp_bub;
      int  guard;
      int  idx;
      bit  acc;
      bit  hit;
      exp_bub = 0;
      for (int k = 0; k < NW; k++) begin
         old[k] = chain_word(chain, k);
         if (k > 0) exp_bub += gap[k];
      end
      mon_clr = 1'b1; @(posedge prog_clk); #1; mon_clr = 1'b0;
      start = 1'b1;   @(posedge prog_clk); #1; start = 1'b0;
      for (int k = 0; k < NW; k++) begin
         if (k > 0 && gap[k] > 0) begin
            cfg_valid = 1'b0;
            repeat (MW - 1 + gap[k]) @(posedge prog_clk);
            #1;
         end
         cfg_valid = 1'b1;
         cfg_word  = w[k];
         if (poke && k == 2) start = 1'b1;
         guard = 0;
         acc   = 1'b0;
         while (!acc && guard < 4*MW) begin
            @(negedge prog_clk); acc = cfg_ready;
            @(posedge prog_clk); #1;
            guard++;
         end
         start = 1'b0;
         chk($sformatf("accept%0d", k), acc, 1);
      end
      cfg_valid = 1'b0;
      hit   = 1'b0;
      guard = 0;
      while (!hit && guard < 4*MW) begin
         @(negedge prog_clk); hit = done;
         if (hit && poke) start = 1'b1;
         @(posedge prog_clk); #1;
         guard++;
      end
      start = 1'b0;
      chk("done_seen", hit, 1);
      repeat (4) @(posedge prog_clk);
      #1;
      chk("shift_count", nshift, LEN);
      chk("bubbles", (last_cyc - first_cyc + 1) - nshift, exp_bub);
      chk("done_count", ndone, 1);
      chk("done_latency", done_cyc - last_cyc, 1);
      chk("done_with_rb", done_rb, 1);
      chk("busy_in_done", done_busy, 0);
      chk("rb_count", rb_q.size(), NW);
      for (int k = 0; k < NW; k++) begin
         for (int b = 0; b < MW; b++) begin
            idx   = k*MW + b;
            hw[b] = (idx < head_q.size()) ? head_q[idx] : 1'b0;
         end
         chk($sformatf("head_word%0d", k), hw, w[k]);
         chk($sformatf("rb_word%0d", k),
             (k < rb_q.size()) ? 32'(rb_q[k]) : 32'hFFFF_FFFF, old[k]);
         chk($sformatf("chain_word%0d", k), chain_word(chain, k), w[k]);
      end
      chk("busy_after", {busy, cfg_ready, ccff_shift_en}, 0);
   endtask

   logic [MW-1:0] wv [NW];
   int            gv [NW];
   int            guard;

   initial begin
      // Reset while idle
      prog_reset_n = 1'b0;
      repeat (3) @(posedge prog_clk);
      #1;
      chk("rst_idle_outs", {busy, done, cfg_ready, ccff_head, ccff_shift_en, rb_valid, rb_word}, 0);
      prog_reset_n = 1'b1;
      @(posedge prog_clk); #1;

      // Reset after three shifts of a load
      mon_clr = 1'b1; @(posedge prog_clk); #1; mon_clr = 1'b0;
      start = 1'b1;   @(posedge prog_clk); #1; start = 1'b0;
      cfg_valid = 1'b1;
      cfg_word  = 7'h7F;
      guard = 0;
      while (nshift < 3 && guard < 20) begin
         @(negedge prog_clk);
         guard++;
      end
      chk("rst_mid_reached", nshift, 3);
      chk("rst_mid_busy_pre", {busy, ccff_shift_en}, 2'b11);
      cfg_valid = 1'b0;
      #1 prog_reset_n = 1'b0;
      #1;
      chk("rst_mid_outs", {busy, done, cfg_ready, ccff_head, ccff_shift_en, rb_valid, rb_word}, 0);
      @(negedge prog_clk) prog_reset_n = 1'b1;
      repeat (10) @(posedge prog_clk);
      #1;
      chk("rst_mid_no_done", ndone, 0);
      chk("rst_mid_idle", {busy, ccff_shift_en, cfg_ready}, 0);

      // cfg_valid in IDLE is ignored
      cfg_valid = 1'b1;
      cfg_word  = 7'h3C;
      for (int i = 0; i < 4; i++) begin
         @(negedge prog_clk);
         chk("idle_ready", {cfg_ready, ccff_shift_en, busy}, 0);
      end
      cfg_valid = 1'b0;
      @(posedge prog_clk); #1;

      // Gapless alternating pattern
      wv = '{7'h55, 7'h2A, 7'h55, 7'h2A};
      gv = '{0, 0, 0, 0};
      do_load(wv, gv, 1'b0);

      // Known contents, then reload and read them back twice
      wv = '{7'h7F, 7'h00, 7'h7F, 7'h00};
      do_load(wv, gv, 1'b0);
      wv = '{7'h55, 7'h2A, 7'h55, 7'h2A};
      do_load(wv, gv, 1'b0);
      chk("reread_w0", chain_word(chain, 0), 7'h55);
      wv = '{7'h2A, 7'h55, 7'h2A, 7'h55};
      do_load(wv, gv, 1'b0);

      // Valid dropped for 5 cycles between words
      wv = '{7'h55, 7'h2A, 7'h55, 7'h2A};
      gv = '{0, 5, 0, 0};
      do_load(wv, gv, 1'b0);

      // start while busy and during done is ignored
      gv = '{0, 0, 2, 0};
      do_load(wv, gv, 1'b1);

      // Random words and gaps
      for (int n = 0; n < 6; n++) begin
         for (int k = 0; k < NW; k++) begin
            wv[k] = MW'($urandom_range(0, (1 << MW) - 1));
            gv[k] = (k == 0) ? 0 : int'($urandom_range(0, 4));
         end
         do_load(wv, gv, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
